// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer pattern driver: proximity codes, channel
// FSM state encoding and a counter-width helper.
package buzz_pkg;

    localparam logic [1:0] BUZZ_OFF   = 2'b00;
    localparam logic [1:0] BUZZ_BOTH  = 2'b01;
    localparam logic [1:0] BUZZ_CLOSE = 2'b10;
    localparam logic [1:0] BUZZ_BAD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONT     = 2'd1,
        ST_BEEP_ON  = 2'd2,
        ST_BEEP_OFF = 2'd3
    } buzz_state_e;

    // Counter width for a terminal count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buzz_channel.sv
// One buzzer channel: debounces the proximity code, runs the pattern FSM and
// registers the gated tone. The FSM state is exported for decode and debug.
module buzz_channel
    import buzz_pkg::*;
#(
    parameter int BEEP_ON_CYC  = 5000000,
    parameter int BEEP_OFF_CYC = 5000000,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  code,
    input  logic        tone_phase,
    output logic        tone,
    output buzz_state_e state,
    output logic        err
);

    localparam int DW = cnt_w(DEBOUNCE_CYC);
    localparam int BW = cnt_w((BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC);

    logic [1:0]    cand_q, cand_d;
    logic [1:0]    acc_q, acc_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    buzz_state_e   state_q, state_d;
    logic          tone_q, tone_d;

    always_comb begin
        cand_d = cand_q;
        acc_d  = acc_q;
        dcnt_d = dcnt_q;
        if (code != cand_q) begin
            cand_d = code;
            dcnt_d = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) begin
            acc_d = cand_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // Code changes are checked before the beep timer so they win on a tie.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_q == BUZZ_BOTH) begin
                    state_d = ST_CONT;
                end else if (acc_q == BUZZ_CLOSE) begin
                    state_d = ST_BEEP_ON;
                    bcnt_d  = '0;
                end
            end
            ST_CONT: begin
                if (acc_q == BUZZ_CLOSE) begin
                    state_d = ST_BEEP_ON;
                    bcnt_d  = '0;
                end else if (acc_q != BUZZ_BOTH) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEEP_ON: begin
                if (acc_q == BUZZ_BOTH) begin
                    state_d = ST_CONT;
                end else if (acc_q != BUZZ_CLOSE) begin
                    state_d = ST_IDLE;
                end else if (bcnt_q == BW'(BEEP_ON_CYC - 1)) begin
                    state_d = ST_BEEP_OFF;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            ST_BEEP_OFF: begin
                if (acc_q == BUZZ_BOTH) begin
                    state_d = ST_CONT;
                end else if (acc_q != BUZZ_CLOSE) begin
                    state_d = ST_IDLE;
                end else if (bcnt_q == BW'(BEEP_OFF_CYC - 1)) begin
                    state_d = ST_BEEP_ON;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tone_d = tone_phase & ((state_q == ST_CONT) || (state_q == ST_BEEP_ON));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q  <= BUZZ_OFF;
            acc_q   <= BUZZ_OFF;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            state_q <= ST_IDLE;
            tone_q  <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            state_q <= state_d;
            tone_q  <= tone_d;
        end
    end

    assign tone  = tone_q;
    assign state = state_q;
    assign err   = (acc_q == BUZZ_BAD);

endmodule

// File: rtl/buzz_pattern_driver.sv
// Left/right buzzer driver: shared tone prescaler, two pattern channels and a
// sticky invalid-code flag.
module buzz_pattern_driver
    import buzz_pkg::*;
#(
    parameter int TONE_HALF    = 25000,
    parameter int BEEP_ON_CYC  = 5000000,
    parameter int BEEP_OFF_CYC = 5000000,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] left_buzz,
    input  logic [1:0] right_buzz,
    output logic       left_tone,
    output logic       right_tone,
    output logic       left_active,
    output logic       right_active,
    output logic       code_err
);

    localparam int TW = cnt_w(TONE_HALF);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tone_phase_q, tone_phase_d;
    logic          code_err_q, code_err_d;
    buzz_state_e   left_state, right_state;
    logic          left_err, right_err;

    always_comb begin
        tcnt_d       = tcnt_q + TW'(1);
        tone_phase_d = tone_phase_q;
        if (tcnt_q == TW'(TONE_HALF - 1)) begin
            tcnt_d       = '0;
            tone_phase_d = ~tone_phase_q;
        end
        code_err_d = code_err_q | left_err | right_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q       <= '0;
            tone_phase_q <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            tcnt_q       <= tcnt_d;
            tone_phase_q <= tone_phase_d;
            code_err_q   <= code_err_d;
        end
    end

    buzz_channel #(
        .BEEP_ON_CYC (BEEP_ON_CYC),
        .BEEP_OFF_CYC(BEEP_OFF_CYC),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_left (
        .clk       (clk),
        .reset_n   (reset_n),
        .code      (left_buzz),
        .tone_phase(tone_phase_q),
        .tone      (left_tone),
        .state     (left_state),
        .err       (left_err)
    );

    buzz_channel #(
        .BEEP_ON_CYC (BEEP_ON_CYC),
        .BEEP_OFF_CYC(BEEP_OFF_CYC),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_right (
        .clk       (clk),
        .reset_n   (reset_n),
        .code      (right_buzz),
        .tone_phase(tone_phase_q),
        .tone      (right_tone),
        .state     (right_state),
        .err       (right_err)
    );

    assign left_active  = (left_state != ST_IDLE);
    assign right_active = (right_state != ST_IDLE);
    assign code_err     = code_err_q;

endmodule

// File: tb/tb_buzz_pattern_driver.sv
// Bench for buzz_pattern_driver: a cycle model pushes expected outputs each
// edge, a negedge monitor pops and compares, plus directed timing checks.
module tb_buzz_pattern_driver;

    localparam int TONE_HALF    = 2;
    localparam int BEEP_ON_CYC  = 8;
    localparam int BEEP_OFF_CYC = 6;
    localparam int DEBOUNCE_CYC = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] left_buzz = 2'b00;
    logic [1:0] right_buzz = 2'b00;
    logic       left_tone, right_tone, left_active, right_active, code_err;

    buzz_pattern_driver #(
        .TONE_HALF   (TONE_HALF),
        .BEEP_ON_CYC (BEEP_ON_CYC),
        .BEEP_OFF_CYC(BEEP_OFF_CYC),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .left_buzz   (left_buzz),
        .right_buzz  (right_buzz),
        .left_tone   (left_tone),
        .right_tone  (right_tone),
        .left_active (left_active),
        .right_active(right_active),
        .code_err    (code_err)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {left_tone, right_tone, left_active, right_active, code_err};
    endfunction

    // Reference model. States: 0 idle, 1 continuous, 2 beep on, 3 beep off.
    int       m_tcnt = 0;
    bit       m_phase = 0;
    bit [1:0] m_cand[2] = '{2'b00, 2'b00};
    bit [1:0] m_acc[2] = '{2'b00, 2'b00};
    int       m_dcnt[2] = '{0, 0};
    int       m_bcnt[2] = '{0, 0};
    int       m_st[2] = '{0, 0};
    bit       m_tone[2] = '{0, 0};
    bit       m_err = 0;

    always @(posedge clk or negedge reset_n) begin : model
        bit [1:0] in_v[2];
        if (!reset_n) begin
            m_tcnt = 0;
            m_phase = 0;
            m_err = 0;
            for (int c = 0; c < 2; c++) begin
                m_cand[c] = 0; m_acc[c] = 0; m_dcnt[c] = 0;
                m_bcnt[c] = 0; m_st[c] = 0; m_tone[c] = 0;
            end
            exp_q.delete();
        end else begin
            in_v[0] = left_buzz;
            in_v[1] = right_buzz;
            if (m_acc[0] == 2'b11 || m_acc[1] == 2'b11) m_err = 1;
            for (int c = 0; c < 2; c++) begin
                m_tone[c] = m_phase && (m_st[c] == 1 || m_st[c] == 2);
                if (m_acc[c] == 2'b00 || m_acc[c] == 2'b11) begin
                    m_st[c] = 0;
                end else if (m_acc[c] == 2'b01) begin
                    m_st[c] = 1;
                end else if (m_st[c] < 2) begin
                    m_st[c] = 2; m_bcnt[c] = 0;
                end else if (m_bcnt[c] == ((m_st[c] == 2) ? BEEP_ON_CYC : BEEP_OFF_CYC) - 1) begin
                    m_st[c] = (m_st[c] == 2) ? 3 : 2; m_bcnt[c] = 0;
                end else begin
                    m_bcnt[c]++;
                end
                if (in_v[c] != m_cand[c]) begin
                    m_cand[c] = in_v[c]; m_dcnt[c] = 0;
                end else if (m_dcnt[c] == DEBOUNCE_CYC - 1) begin
                    m_acc[c] = m_cand[c];
                end else begin
                    m_dcnt[c]++;
                end
            end
            if (m_tcnt == TONE_HALF - 1) begin
                m_tcnt = 0; m_phase = ~m_phase;
            end else begin
                m_tcnt++;
            end
            exp_q.push_back({m_tone[0], m_tone[1], m_st[0] != 0, m_st[1] != 0, m_err});
        end
    end

    always @(negedge clk) begin : monitor
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outs", {27'd0, outs()}, {27'd0, e});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int tg, cnt;
        logic prev;
        // 1: reset with a live code, then idle inputs
        left_buzz = 2'b10;
        cycles(3);
        check("rst_outs", {27'd0, outs()}, 32'd0);
        left_buzz = 2'b00;
        reset_n = 1'b1;
        cycles(50);
        check("idle_outs", {27'd0, outs()}, 32'd0);

        // 2: continuous tone on the left
        left_buzz = 2'b01;
        cycles(4);
        check("lact_early", {31'd0, left_active}, 32'd0);
        cycles(1);
        check("lact_on", {31'd0, left_active}, 32'd1);
        cycles(4);
        tg = 0;
        prev = left_tone;
        repeat (16) begin
            @(negedge clk);
            if (left_tone != prev) tg++;
            prev = left_tone;
        end
        check("ltone_toggles", tg, 8);
        check("right_quiet", {30'd0, right_tone, right_active}, 32'd0);

        // 3: beeping on the right
        right_buzz = 2'b10;
        cycles(6);
        cnt = 0;
        repeat (42) begin
            @(negedge clk);
            if (right_active) cnt++;
        end
        check("ract_cycles", cnt, 42);

        // 4: short pulse is rejected
        left_buzz = 2'b00;
        cycles(10);
        check("lidle", {31'd0, left_active}, 32'd0);
        left_buzz = 2'b10;
        cycles(2);
        left_buzz = 2'b00;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (left_active || left_tone) cnt++;
        end
        check("pulse_reject", cnt, 0);

        // 5: beep, switch to continuous mid BEEP_ON, then off
        left_buzz = 2'b10;
        cycles(8);
        left_buzz = 2'b01;
        cycles(12);
        check("lcont_act", {31'd0, left_active}, 32'd1);
        left_buzz = 2'b00;
        cycles(4);
        check("lact_hold", {31'd0, left_active}, 32'd1);
        cycles(1);
        check("lact_fall", {31'd0, left_active}, 32'd0);
        cycles(1);
        check("ltone_off", {31'd0, left_tone}, 32'd0);

        // 6: invalid code sets the sticky flag; async reset mid-beep
        right_buzz = 2'b11;
        cycles(5);
        right_buzz = 2'b00;
        cycles(10);
        check("code_err_sticky", {31'd0, code_err}, 32'd1);
        check("right_idle", {31'd0, right_active}, 32'd0);
        left_buzz = 2'b10;
        cycles(12);
        check("lbeep_act", {31'd0, left_active}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_rst", {27'd0, outs()}, 32'd0);
        cycles(2);
        reset_n = 1'b1;
        cycles(20);
        check("post_rst_err", {31'd0, code_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
